// File: rtl/i2c_link_master.sv
// i2c_link_master: byte-level I2C master sequencing the DAQ, TRG and NVIO links
// Host side: START/BUS_SEL/RW/DEV_ADDR/NB_M1/WDATA in; BUSY/DONE/NACK_ERR/RDATA out.
// Pad side per link: SDA_DIR (IOBUF T, 1 = release), SDA_OUT (tied 0), SDA_IN, SCL_OUT.
// NVIO_I2C_ENB: active-low translator enable, low while an NVIO transaction is busy.
module i2c_link_master #(
   parameter int CLK_DIV = 100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [1:0]  BUS_SEL,
   input  logic        RW,
   input  logic [6:0]  DEV_ADDR,
   input  logic [1:0]  NB_M1,
   input  logic [31:0] WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic        NACK_ERR,
   output logic [31:0] RDATA,
   output logic        DAQ_SDA_DIR,
   output logic        TRG_SDA_DIR,
   output logic        NVIO_SDA_DIR,
   output logic        DAQ_SDA_OUT,
   output logic        TRG_SDA_OUT,
   output logic        NVIO_SDA_OUT,
   input  logic        DAQ_SDA_IN,
   input  logic        TRG_SDA_IN,
   input  logic        NVIO_SDA_IN,
   output logic        DAQ_SCL_OUT,
   output logic        TRG_SCL_OUT,
   output logic        NVIO_SCL_OUT,
   output logic        NVIO_I2C_ENB
);
   localparam logic [2:0] IDLE = 3'd0, STA = 3'd1, BIT = 3'd2, ACK = 3'd3, STO = 3'd4, FIN = 3'd5;
   logic [2:0]  st, bc;
   logic [1:0]  q, sel, nb, bi;
   logic [9:0]  cnt;
   logic        tick, rw, first, ack_s, slave_ack, rd_phase, last, scl, rel, sda_in;
   logic [7:0]  sr, rx;
   logic [31:0] wd;
   assign tick      = cnt == 10'(CLK_DIV - 1);
   assign BUSY      = st != IDLE;
   // slave drives the ACK slot after the address byte and after every written byte
   assign slave_ack = first | ~rw;
   assign rd_phase  = rw & ~first;
   assign last      = bi == nb;
   assign sda_in    = (sel == 2'd0) ? DAQ_SDA_IN : (sel == 2'd1) ? TRG_SDA_IN : NVIO_SDA_IN;
   assign scl = (st == BIT || st == ACK) ? (q == 2'd1 || q == 2'd2) :
                (st == STO) ? (q != 2'd0) : 1'b1;
   // in a read, the master ACKs every byte but the last, which is NACKed by releasing
   assign rel = (st == STA) ? 1'b0 :
                (st == BIT) ? (rd_phase | sr[7]) :
                (st == ACK) ? (slave_ack | last) :
                (st == STO) ? (q == 2'd2) : 1'b1;
   assign DAQ_SDA_DIR  = (sel == 2'd0) ? rel : 1'b1;
   assign TRG_SDA_DIR  = (sel == 2'd1) ? rel : 1'b1;
   assign NVIO_SDA_DIR = (sel == 2'd2) ? rel : 1'b1;
   assign DAQ_SCL_OUT  = (sel == 2'd0) ? scl : 1'b1;
   assign TRG_SCL_OUT  = (sel == 2'd1) ? scl : 1'b1;
   assign NVIO_SCL_OUT = (sel == 2'd2) ? scl : 1'b1;
   assign DAQ_SDA_OUT  = 1'b0;
   assign TRG_SDA_OUT  = 1'b0;
   assign NVIO_SDA_OUT = 1'b0;
   assign NVIO_I2C_ENB = ~(BUSY & (sel == 2'd2));
   always_ff @(posedge CLK) begin
      if (RST) begin
         st       <= IDLE;
         q        <= '0;
         cnt      <= '0;
         sel      <= '0;
         nb       <= '0;
         bi       <= '0;
         bc       <= '0;
         rw       <= 1'b0;
         first    <= 1'b0;
         ack_s    <= 1'b0;
         sr       <= '0;
         rx       <= '0;
         wd       <= '0;
         DONE     <= 1'b0;
         NACK_ERR <= 1'b0;
         RDATA    <= '0;
      end else begin
         DONE <= 1'b0;
         cnt  <= (st == IDLE || tick) ? '0 : cnt + 10'd1;
         if (st == IDLE) begin
            if (START) begin
               sel      <= BUS_SEL;
               rw       <= RW;
               nb       <= NB_M1;
               sr       <= {DEV_ADDR, RW};
               wd       <= WDATA;
               first    <= 1'b1;
               bi       <= '0;
               bc       <= '0;
               q        <= '0;
               NACK_ERR <= 1'b0;
               RDATA    <= '0;
               st       <= (BUS_SEL == 2'd3) ? FIN : STA;
            end
         end else if (st == FIN) begin
            DONE <= 1'b1;
            st   <= IDLE;
            if (sel == 2'd3) NACK_ERR <= 1'b1;
         end else if (tick) begin
            q <= q + 2'd1;
            case (st)
               STA: if (q == 2'd1) begin
                  st <= BIT;
                  q  <= '0;
               end
               BIT: begin
                  if (q == 2'd2 && rd_phase) rx <= {rx[6:0], sda_in};
                  if (q == 2'd3) begin
                     sr <= {sr[6:0], 1'b0};
                     bc <= bc + 3'd1;
                     if (bc == 3'd7) begin
                        st <= ACK;
                        if (rd_phase) RDATA[{bi, 3'b000} +: 8] <= rx;
                     end
                  end
               end
               ACK: begin
                  if (q == 2'd2) ack_s <= sda_in;
                  if (q == 2'd3) begin
                     if (slave_ack && ack_s) begin
                        NACK_ERR <= 1'b1;
                        st       <= STO;
                     end else if (!first && last) begin
                        st <= STO;
                     end else begin
                        st    <= BIT;
                        first <= 1'b0;
                        if (!first) bi <= bi + 2'd1;
                        sr    <= wd[7:0];
                        wd    <= {8'd0, wd[31:8]};
                     end
                  end
               end
               STO: if (q == 2'd2) begin
                  st <= FIN;
                  q  <= '0;
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_i2c_link_master.sv
// tb_i2c_link_master: randomized bench with behavioural I2C slave and bus monitor
module tb_i2c_link_master;
   localparam int CLK_DIV = 4;
   logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, RW = 1'b0;
   logic [1:0]  BUS_SEL = '0, NB_M1 = '0;
   logic [6:0]  DEV_ADDR = '0;
   logic [31:0] WDATA = '0, RDATA;
   logic        BUSY, DONE, NACK_ERR, nvio_enb;
   logic [2:0]  dir, sout, scl, line;
   int          n_chk = 0, n_err = 0;
   logic [1:0]  t_sel = 2'd3;
   logic        t_rw = 1'b0, t_anack = 1'b0;
   int          t_dnack = 7, t_nb = 0;
   logic [31:0] t_rb = '0;
   logic        clr = 1'b1, active, rose, psc, pln, other_bad, enb_bad, s_rel, sc, ln;
   int          cur, starts, stops, nbits;
   logic [63:0] bits;
   always #5 CLK = ~CLK;
   i2c_link_master #(.CLK_DIV(CLK_DIV)) dut (
      .CLK(CLK), .RST(RST), .START(START), .BUS_SEL(BUS_SEL), .RW(RW), .DEV_ADDR(DEV_ADDR),
      .NB_M1(NB_M1), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .NACK_ERR(NACK_ERR), .RDATA(RDATA),
      .DAQ_SDA_DIR(dir[0]), .TRG_SDA_DIR(dir[1]), .NVIO_SDA_DIR(dir[2]),
      .DAQ_SDA_OUT(sout[0]), .TRG_SDA_OUT(sout[1]), .NVIO_SDA_OUT(sout[2]),
      .DAQ_SDA_IN(line[0]), .TRG_SDA_IN(line[1]), .NVIO_SDA_IN(line[2]),
      .DAQ_SCL_OUT(scl[0]), .TRG_SCL_OUT(scl[1]), .NVIO_SCL_OUT(scl[2]),
      .NVIO_I2C_ENB(nvio_enb)
   );
   // slave release for bit c counted from START: 9-bit frames, frame 0 is the address
   function automatic logic slave_rel(input logic act, input int c, input logic rw, input logic an,
                                      input int dn, input int nb, input logic [31:0] rb);
      int f, p;
      if (!act || c < 0) return 1'b1;
      f = c / 9;
      p = c % 9;
      if (f == 0) return (p == 8) ? an : 1'b1;
      if (an || f - 1 > nb) return 1'b1;
      if (!rw) return (p == 8) ? (f - 1 == dn) : 1'b1;
      return (p < 8) ? rb[8 * (f - 1) + 7 - p] : 1'b1;
   endfunction
   assign s_rel = slave_rel(active, cur, t_rw, t_anack, t_dnack, t_nb, t_rb);
   assign line  = dir & ~((t_sel != 2'd3 && !s_rel) ? (3'b001 << t_sel) : 3'b000);
   assign sc    = (t_sel != 2'd3) ? scl[t_sel] : 1'b1;
   assign ln    = (t_sel != 2'd3) ? line[t_sel] : 1'b1;
   always @(negedge CLK) begin
      if (clr) begin
         starts <= 0; stops <= 0; nbits <= 0; bits <= '0; cur <= -1;
         active <= 1'b0; rose <= 1'b0; psc <= 1'b1; pln <= 1'b1;
         other_bad <= 1'b0; enb_bad <= 1'b0;
      end else begin
         psc <= sc;
         pln <= ln;
         if (t_sel != 2'd3) begin
            if (psc && sc && pln && !ln) begin
               starts <= starts + 1; active <= 1'b1; cur <= -1; rose <= 1'b0;
            end else if (psc && sc && !pln && ln) begin
               stops <= stops + 1; active <= 1'b0;
            end
            if (!psc && sc && active) rose <= 1'b1;
            if (psc && !sc && active) begin
               cur <= cur + 1;
               if (rose) begin
                  bits  <= {bits[62:0], pln};
                  nbits <= nbits + 1;
               end
            end
         end
         for (int k = 0; k < 3; k++)
            if (2'(k) != t_sel && (dir[k] !== 1'b1 || scl[k] !== 1'b1)) other_bad <= 1'b1;
         if (sout !== 3'b000) other_bad <= 1'b1;
         if (nvio_enb !== !(t_sel == 2'd2 && BUSY)) enb_bad <= 1'b1;
      end
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge CLK);
      #1 clr = 1'b0;
   endtask
   task automatic run_txn(input logic [1:0] sel, input logic rw, input logic [6:0] addr, input int nb,
                          input logic [31:0] wd, input logic [31:0] rb, input logic anack,
                          input int dnack, input int poke, input int extra);
      logic [63:0] eb;
      logic [31:0] erd;
      logic [7:0]  b;
      logic        enack, a, got;
      int          en, frames, ecyc, cyc, dn;
      eb = '0; erd = '0; en = 0; enack = 1'b0; frames = 0; ecyc = 1;
      if (sel == 2'd3) enack = 1'b1;
      else begin
         b = {addr, rw};
         for (int j = 7; j >= 0; j--) eb = {eb[62:0], b[j]};
         eb = {eb[62:0], anack};
         en = 9;
         frames = 1;
         if (anack) enack = 1'b1;
         else for (int i = 0; i <= nb; i++) begin
            b = rw ? rb[8 * i +: 8] : wd[8 * i +: 8];
            a = rw ? (i == nb) : (i == dnack);
            for (int j = 7; j >= 0; j--) eb = {eb[62:0], b[j]};
            eb = {eb[62:0], a};
            en += 9;
            frames++;
            if (rw) erd[8 * i +: 8] = b;
            if (!rw && a) begin
               enack = 1'b1;
               break;
            end
         end
         ecyc = (2 + 36 * frames + 3) * CLK_DIV;
      end
      t_sel = sel; t_rw = rw; t_anack = anack; t_dnack = dnack; t_nb = nb; t_rb = rb;
      pulse_clr();
      BUS_SEL = sel; RW = rw; DEV_ADDR = addr; NB_M1 = 2'(nb); WDATA = wd; START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (cyc < 4000 && !got) begin
         @(posedge CLK);
         #1 cyc++;
         START = (poke != 0 && cyc == poke);
         if (START) BUS_SEL = 2'd3;
         if (DONE) got = 1'b1;
      end
      START = 1'b0;
      check("done_seen", got, 1'b1);
      check($sformatf("duration cyc=%0d want=%0d", cyc, ecyc), (cyc >= ecyc - 2 && cyc <= ecyc + 2), 1'b1);
      check("busy_at_done", BUSY, 1'b0);
      check("nack_err", NACK_ERR, enack);
      check("rdata", RDATA, erd);
      check("nbits", nbits, en);
      check("bits", bits, eb);
      check("starts", starts, sel != 2'd3);
      check("stops", stops, sel != 2'd3);
      dn = 0;
      repeat (extra) begin
         @(posedge CLK);
         #1 if (DONE) dn++;
      end
      check("extra_done", dn, 0);
      check("other_pads_idle", other_bad, 1'b0);
      check("nvio_enb", enb_bad, 1'b0);
   endtask
   initial begin
      logic [1:0]  rs;
      logic [31:0] rrb;
      int          rnb;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy", BUSY, 1'b0);
      check("rst_done", DONE, 1'b0);
      check("rst_nack", NACK_ERR, 1'b0);
      check("rst_rdata", RDATA, 32'd0);
      check("rst_dir", dir, 3'b111);
      check("rst_scl", scl, 3'b111);
      check("rst_sout", sout, 3'b000);
      check("rst_enb", nvio_enb, 1'b1);
      RST = 1'b0;
      run_txn(2'd0, 1'b0, 7'h50, 0, 32'h0000_00A5, 32'd0, 1'b0, 7, 0, 3);
      run_txn(2'd1, 1'b1, 7'h51, 1, 32'd0, 32'h0000_C33C, 1'b0, 7, 0, 3);
      run_txn(2'd2, 1'b0, 7'h2A, 2, 32'h0011_2233, 32'd0, 1'b1, 7, 0, 3);
      run_txn(2'd3, 1'b0, 7'h11, 0, 32'd0, 32'd0, 1'b0, 7, 0, 3);
      run_txn(2'd0, 1'b0, 7'h10, 1, 32'h0000_5A5A, 32'd0, 1'b0, 7, 50, 400);
      run_txn(2'd1, 1'b0, 7'h33, 3, 32'hDEAD_BEEF, 32'd0, 1'b0, 1, 0, 3);
      rrb = $urandom;
      t_sel = 2'd1; t_rw = 1'b1; t_anack = 1'b0; t_dnack = 7; t_nb = 3; t_rb = rrb;
      pulse_clr();
      BUS_SEL = 2'd1; RW = 1'b1; DEV_ADDR = 7'h44; NB_M1 = 2'd3; START = 1'b1;
      @(posedge CLK);
      #1 START = 1'b0;
      repeat (339) @(posedge CLK);
      #1;
      check("mid_rdata", RDATA[7:0], rrb[7:0]);
      check("mid_busy", BUSY, 1'b1);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_scl", scl, 3'b111);
      check("midrst_dir", dir, 3'b111);
      check("midrst_busy", BUSY, 1'b0);
      check("midrst_rdata", RDATA, 32'd0);
      RST = 1'b0;
      run_txn(2'd1, 1'b0, 7'h3C, 1, 32'h0000_81C7, 32'd0, 1'b0, 7, 0, 3);
      repeat (12) begin
         rs  = 2'($urandom_range(0, 3));
         rnb = int'($urandom_range(0, 3));
         run_txn(rs, 1'($urandom_range(0, 1)), 7'($urandom), rnb, $urandom, $urandom,
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rnb)) : 7,
                 0, 3);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_link_master.md
Name: i2c_link_master

Overview:
- Byte-level I2C master that sequences the three on-board I2C links: DAQ optical-module link, TRG optical-module link, and NVIO 2.5 V link.
- Owns SDA tristate control, SDA output and SCL output for each link, which feed the existing IOBUF/OBUF pad cells.
- Accepts one transaction at a time from a host (register block or JTAG user logic): START, 7-bit address, 1–4 data bytes (write or read) with ACK checking, STOP.
- Unselected links remain in bus-idle state.

Parameters:
- CLK_DIV, 100: CLK cycles per quarter SCL period; 40 MHz CLK → 100 kHz SCL. Legal range 2..1023.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-high reset
- START  in  1  one-cycle request pulse; honoured only when BUSY=0
- BUS_SEL  in  2  link select: 0 DAQ, 1 TRG, 2 NVIO, 3 invalid
- RW  in  1  1 = read, 0 = write
- DEV_ADDR  in  7  slave address
- NB_M1  in  2  byte count minus 1 (1..4 bytes)
- WDATA  in  32  write bytes; byte0 = WDATA[7:0] sent first
- BUSY  out  1  transaction in progress
- DONE  out  1  one-cycle completion pulse
- NACK_ERR  out  1  last transaction failed; valid from DONE until next accepted START
- RDATA  out  32  read bytes; first received byte → [7:0]; unread bytes zero
- DAQ_SDA_DIR, TRG_SDA_DIR, NVIO_SDA_DIR  out  1 each  IOBUF T: 1 = release, 0 = drive
- DAQ_SDA_OUT, TRG_SDA_OUT, NVIO_SDA_OUT  out  1 each  IOBUF I; constant 0 (open-drain emulation)
- DAQ_SDA_IN, TRG_SDA_IN, NVIO_SDA_IN  in  1 each  IOBUF O
- DAQ_SCL_OUT, TRG_SCL_OUT, NVIO_SCL_OUT  out  1 each  push-pull SCL
- NVIO_I2C_ENB  out  1  active-low NVIO translator enable

Behaviour:
- Reset / idle values: BUSY=0, DONE=0, NACK_ERR=0, RDATA=0, all SDA_DIR=1, all SDA_OUT=0, all SCL_OUT=1, NVIO_I2C_ENB=1.
- RST mid-transaction: same values at the next edge; no STOP is generated.
- Quarter tick: divider counts 0..CLK_DIV-1 and pulses at terminal count. Divider is cleared when START is accepted. State advances only on ticks.
- Accept: START with BUSY=0 latches BUS_SEL, RW, DEV_ADDR, NB_M1 and WDATA; sets BUSY=1; clears NACK_ERR and RDATA next cycle. START while BUSY=1 is ignored.
- BUS_SEL=3 on accept: no pad activity. DONE=1 and NACK_ERR=1 one cycle after accept; BUSY falls with DONE.
- NVIO_I2C_ENB=0 from accept to DONE when BUS_SEL=2.
- FSM states: IDLE, STA, BIT, ACK, STO, FIN.
- STA, 2 quarters: q0 SDA driven low with SCL=1; q1 hold.
- BIT / ACK phases, 4 quarters each:
  - q0: SCL=0, SDA updated.
  - q1: SCL=1.
  - q2: SCL=1; SDA_IN sampled at q2 end.
  - q3: SCL=0.
- Transmit bits MSB first; a 1 = released (DIR=1), a 0 = driven (DIR=0).
- Frame order:
  - Address byte {DEV_ADDR, RW}, then slave ACK.
  - Write: NB_M1+1 data bytes, each followed by a slave ACK.
  - Read: SDA released for 8 bits; master drives ACK (SDA low) after each byte except the last, which gets NACK (released).
- Slave ACK sampled 1 (NACK): set NACK_ERR=1 and skip the remaining bytes to STO.
- STO, 3 quarters: q0 SCL=0, SDA low; q1 SCL=1, SDA low; q2 SDA released.
- FIN: DONE=1 for one cycle and BUSY=0 on the same cycle, at most 2 CLK after the final tick. A new START is accepted the cycle after DONE.
- Only the selected link's pads toggle; the other two hold idle values throughout.
- Duration, N bytes, no NACK: 2 + 36·(N+1) + 3 quarters.

Test Plan:
- CLK_DIV=4, write BUS_SEL=0, addr 0x50, NB_M1=0, WDATA[7:0]=0xA5, slave ACKs all bits.
  → DAQ SDA sequence 0xA0, ACK, 0xA5, ACK; DONE 308±2 cycles after START; NACK_ERR=0; TRG/NVIO pads idle throughout.
- Read BUS_SEL=1, addr 0x51, NB_M1=1, slave returns 0x3C then 0xC3.
  → RDATA=0x0000C33C; master ACK after byte0, NACK after byte1; STOP seen on TRG.
- Write BUS_SEL=2, slave NACKs the address.
  → no data bits; STOP follows immediately; NACK_ERR=1 at DONE; NVIO_I2C_ENB low accept→DONE, then 1.
- BUS_SEL=3 START.
  → DONE and NACK_ERR=1 one cycle after accept; no pad toggles.
- Second START pulsed while BUSY=1.
  → ignored; only one DONE.
- RST asserted mid data byte.
  → next edge: SCL=1, SDA_DIR=1, BUSY=0, RDATA=0; new START then completes normally.
